// File: rtl/y86_state_loader.sv
// Debug-side architectural state injector: stalls the core, receives PC + eax..edi
// over valid/ready, then commits them. Optional frame checksum: Y86_LOADER_CHECKSUM_EN.
module y86_state_loader #(
    parameter int DRAIN_CYCLES = 4,
    parameter int WORD_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              cpu_stall,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [WORD_W-1:0] rf_wdata,
    output logic              pc_we,
    output logic [WORD_W-1:0] pc_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state  | meaning
    // IDLE   | waiting for start
    // HALT   | CPU stalled, letting the pipeline drain
    // RECV   | accepting frame words
    // COMMIT | writing r0..r7 (and PC in the first cycle)
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_HALT, S_RECV, S_COMMIT, S_DONE} state_t;

`ifdef Y86_LOADER_CHECKSUM_EN
    localparam int FRAME_WORDS = 10;
`else
    localparam int FRAME_WORDS = 9;
`endif
    localparam logic [3:0] LAST_WORD  = 4'(FRAME_WORDS - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t            state, state_n;
    logic [3:0]        timer;
    logic [3:0]        word_cnt;
    logic [2:0]        cidx;
    logic [WORD_W-1:0] buffer [0:8];
    logic              xfer, last_xfer;

    assign xfer      = (state == S_RECV) && in_valid;
    assign last_xfer = xfer && (word_cnt == LAST_WORD);

`ifdef Y86_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] xor_acc;
    logic              err_q;
    logic              chk_bad;
    assign chk_bad = (xor_acc != in_data);
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_HALT;
            S_HALT:   if (timer == 4'd0) state_n = S_RECV;
            S_RECV: begin
                if (last_xfer) begin
`ifdef Y86_LOADER_CHECKSUM_EN
                    state_n = chk_bad ? S_DONE : S_COMMIT;
`else
                    state_n = S_COMMIT;
`endif
                end
            end
            S_COMMIT: if (cidx == 3'd7) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= 4'd0;
            word_cnt <= 4'd0;
            cidx     <= 3'd0;
        end else begin
            state <= state_n;
            if (state == S_IDLE)
                timer <= DRAIN_LOAD;
            else if ((state == S_HALT) && (timer != 4'd0))
                timer <= timer - 4'd1;
            if (state != S_RECV)
                word_cnt <= 4'd0;
            else if (xfer)
                word_cnt <= word_cnt + 4'd1;
            if (state != S_COMMIT)
                cidx <= 3'd0;
            else
                cidx <= cidx + 3'd1;
        end
    end

`ifdef Y86_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            xor_acc <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != S_RECV)
                xor_acc <= '0;
            else if (xfer)
                xor_acc <= xor_acc ^ in_data;
            if (state == S_IDLE)
                err_q <= 1'b0;
            else if (last_xfer)
                err_q <= chk_bad;
        end
    end
    assign err = (state == S_DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    // The checksum word (index 9) is only folded into xor_acc, never stored.
    always_ff @(posedge clk) begin
        if (xfer && (word_cnt <= 4'd8))
            buffer[word_cnt] <= in_data;
    end

    assign in_ready  = (state == S_RECV);
    assign cpu_stall = (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rf_we     = (state == S_COMMIT);
    assign rf_waddr  = (state == S_COMMIT) ? cidx : 3'd0;
    assign rf_wdata  = (state == S_COMMIT) ? buffer[{1'b0, cidx} + 4'd1] : '0;
    assign pc_we     = (state == S_COMMIT) && (cidx == 3'd0);
    assign pc_wdata  = pc_we ? buffer[0] : '0;

endmodule

// File: tb/tb_y86_state_loader.sv
// Self-checking bench for y86_state_loader: timeline-based reference model plus directed and random loads.
module tb_y86_state_loader;

    localparam int DR = 4;
`ifdef Y86_LOADER_CHECKSUM_EN
    localparam int NW = 10;
`else
    localparam int NW = 9;
`endif

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic [31:0] in_data;
    logic        in_ready, cpu_stall, rf_we, pc_we, busy, done, err;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata, pc_wdata;

    y86_state_loader #(.DRAIN_CYCLES(DR), .WORD_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_stall(cpu_stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .pc_we(pc_we), .pc_wdata(pc_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fail_prints = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (fail_prints < 60) begin
                fail_prints++;
                $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
            end
        end
    endtask

    // Reference model: a load is a timeline. Stall starts the cycle after start,
    // words are accepted from DR cycles later, commits fill the 8 cycles after
    // the last word, and done follows (or immediately follows the last word on a bad checksum).
    bit          m_active = 0;
    int          m_cyc = 0, m_t0 = 0, m_tl = 0, m_nw = 0;
    bit          m_bad = 0;
    logic [31:0] m_frame [0:9];

    function automatic bit frame_bad();
`ifdef Y86_LOADER_CHECKSUM_EN
        logic [31:0] x;
        x = 32'h0;
        for (int i = 0; i < 9; i++) x ^= m_frame[i];
        return (m_frame[9] != x);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit rdy_prev;
        int kk;
        rdy_prev = m_active && (m_cyc >= m_t0 + DR) && (m_nw < NW);
        if (reset) m_active = 0;
        else if (m_active) begin
            if (abort) m_active = 0;
            else if (m_nw == NW) begin
                kk = m_cyc - m_tl - 1;
                if (kk == (m_bad ? 0 : 8)) m_active = 0;
            end else if (rdy_prev && in_valid) begin
                m_frame[m_nw] = in_data;
                m_nw++;
                if (m_nw == NW) begin
                    m_tl  = m_cyc;
                    m_bad = frame_bad();
                end
            end
        end else if (start) begin
            m_active = 1;
            m_t0 = m_cyc + 1;
            m_nw = 0;
            m_bad = 0;
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        logic        e_rdy, e_act, e_we, e_pwe, e_done, e_err;
        logic [2:0]  e_addr;
        logic [31:0] e_wd, e_pd;
        int k;
        if (chk_en) begin
            e_rdy = 0; e_act = 0; e_we = 0; e_pwe = 0; e_done = 0; e_err = 0;
            e_addr = 3'd0; e_wd = 32'h0; e_pd = 32'h0;
            if (m_active) begin
                e_act = 1;
                e_rdy = (m_cyc >= m_t0 + DR) && (m_nw < NW);
                if (m_nw == NW) begin
                    k = m_cyc - m_tl - 1;
                    if (!m_bad && k >= 0 && k < 8) begin
                        e_we = 1;
                        e_addr = 3'(k);
                        e_wd = m_frame[k + 1];
                        if (k == 0) begin
                            e_pwe = 1;
                            e_pd = m_frame[0];
                        end
                    end
                    e_done = (k == (m_bad ? 0 : 8));
                    e_err  = e_done && m_bad;
                end
            end
            check("in_ready",  {31'h0, in_ready},  {31'h0, e_rdy});
            check("cpu_stall", {31'h0, cpu_stall}, {31'h0, e_act});
            check("busy",      {31'h0, busy},      {31'h0, e_act});
            check("rf_we",     {31'h0, rf_we},     {31'h0, e_we});
            check("rf_waddr",  {29'h0, rf_waddr},  {29'h0, e_addr});
            check("rf_wdata",  rf_wdata,           e_wd);
            check("pc_we",     {31'h0, pc_we},     {31'h0, e_pwe});
            check("pc_wdata",  pc_wdata,           e_pd);
            check("done",      {31'h0, done},      {31'h0, e_done});
            check("err",       {31'h0, err},       {31'h0, e_err});
        end
    end

    logic [31:0] src [0:9];
    logic [31:0] shadow [0:7];
    logic [31:0] shadow_pc;
    int n_done, n_rf, n_pc, n_rdy, n_err, first_rdy, done_at;

    task automatic set_xor(input bit flip);
        logic [31:0] x;
        x = 32'h0;
        for (int i = 0; i < 9; i++) x ^= src[i];
        src[9] = x ^ {31'h0, flip};
    endtask

    task automatic fill_directed();
        src[0] = 32'h0000_0100;
        for (int i = 1; i < 9; i++) src[i] = 32'h1111_1111 * i;
        set_xor(1'b0);
    endtask

    // vmode: 0 valid always high, 1 valid on alternate RECV cycles, 2 random.
    // stop_k >= 0 aborts (or resets) in that commit cycle; abort_j > 0 aborts at that load cycle.
    task automatic run_load(input int vmode, input int stop_k, input bit use_reset,
                            input bit restart, input int abort_j);
        int j;
        bit stop_now;
        n_done = 0; n_rf = 0; n_pc = 0; n_rdy = 0; n_err = 0; first_rdy = -1; done_at = -1;
        for (int i = 0; i < 8; i++) shadow[i] = 32'hdead_beef;
        shadow_pc = 32'hdead_beef;
        @(negedge clk);
        start = 1; in_valid = 0;
        @(negedge clk);
        start = 0;
        j = 1;
        forever begin
            if (in_ready) begin n_rdy++; if (first_rdy < 0) first_rdy = j; end
            if (rf_we) begin n_rf++; shadow[rf_waddr] = rf_wdata; end
            if (pc_we) begin n_pc++; shadow_pc = pc_wdata; end
            if (done) begin n_done++; done_at = j; if (err) n_err++; end
            if (!m_active) break;
            if (j > 400) begin
                check("load_timeout", 32'(j), 32'd400);
                break;
            end
            in_data = (m_nw < NW) ? src[m_nw] : $urandom;
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (j >= DR + 1) && (((j - DR - 1) % 2) == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            start = restart && (j == DR + 3);
            stop_now = (abort_j > 0 && j == abort_j) ||
                       (stop_k >= 0 && m_nw == NW && (m_cyc - m_tl - 1) == stop_k);
            reset = use_reset && stop_now;
            abort = !use_reset && stop_now;
            @(negedge clk);
            j++;
        end
        start = 0; abort = 0; reset = 0; in_valid = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; in_valid = 0; in_data = 32'h0;
        @(posedge clk);
        #1 chk_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 0;
        repeat (20) @(negedge clk);
        check("idle_busy", {31'h0, busy}, 32'd0);

        // Directed load, valid always high.
        fill_directed();
        run_load(0, -1, 0, 0, 0);
        check("ready_rise_cycle", 32'(first_rdy), 32'd5);
        check("done_cycle", 32'(done_at), 32'(1 + DR + NW + 8));
        check("done_count", 32'(n_done), 32'd1);
        check("pc_we_count", 32'(n_pc), 32'd1);
        check("pc_value", shadow_pc, 32'h0000_0100);
        check("rf_we_count", 32'(n_rf), 32'd8);
        check("r0", shadow[0], 32'h1111_1111);
        check("r3", shadow[3], 32'h4444_4444);
        check("r7", shadow[7], 32'h8888_8888);

        // Valid toggling: RECV stretches to 2N-1 cycles, commits unchanged.
        run_load(1, -1, 0, 0, 0);
        check("toggle_recv_len", 32'(n_rdy), 32'(2 * NW - 1));
        check("toggle_r5", shadow[5], 32'h6666_6666);
        check("toggle_pc", shadow_pc, 32'h0000_0100);
        check("toggle_done", 32'(n_done), 32'd1);

        // Abort in commit cycle 3.
        run_load(0, 3, 0, 0, 0);
        check("abort_rf_count", 32'(n_rf), 32'd4);
        check("abort_pc_count", 32'(n_pc), 32'd1);
        check("abort_done", 32'(n_done), 32'd0);
        check("abort_r3", shadow[3], 32'h4444_4444);

        // Reset in commit cycle 3.
        run_load(0, 3, 1, 0, 0);
        check("reset_rf_count", 32'(n_rf), 32'd4);
        check("reset_done", 32'(n_done), 32'd0);

        // Start pulsed during RECV is ignored.
        run_load(0, -1, 0, 1, 0);
        check("restart_done", 32'(n_done), 32'd1);
        check("restart_done_cycle", 32'(done_at), 32'(1 + DR + NW + 8));
        repeat (10) @(negedge clk);
        check("restart_idle", {31'h0, busy}, 32'd0);

`ifdef Y86_LOADER_CHECKSUM_EN
        set_xor(1'b0);
        run_load(0, -1, 0, 0, 0);
        check("csum_ok_rf", 32'(n_rf), 32'd8);
        check("csum_ok_err", 32'(n_err), 32'd0);
        set_xor(1'b1);
        run_load(0, -1, 0, 0, 0);
        check("csum_bad_rf", 32'(n_rf), 32'd0);
        check("csum_bad_pc", 32'(n_pc), 32'd0);
        check("csum_bad_done", 32'(n_done), 32'd1);
        check("csum_bad_err", 32'(n_err), 32'd1);
`endif

        // Random frames, random valid, occasional aborts.
        for (int it = 0; it < 12; it++) begin
            int sel;
            for (int i = 0; i < 9; i++) src[i] = $urandom;
            set_xor(1'($urandom_range(0, 3) == 0));
            sel = $urandom_range(0, 3);
            if (sel == 0)
                run_load(2, -1, 0, 0, $urandom_range(1, 30));
            else if (sel == 1)
                run_load(2, $urandom_range(0, 7), 0, 0, 0);
            else
                run_load(2, -1, 0, 0, 0);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
